cycle_count_reporter: RTL

CYCLE_COUNT_REPORTER -- requirements
Module: cycle_count_reporter

---
 rtl/cycle_count_reporter.sv | 114 +++++++++++
 1 files changed

// File: rtl/cycle_count_reporter.sv
// Snapshots a cycle count on request and streams it out as uppercase ASCII hex,
// MSB nibble first, optionally terminated with CR LF, over a valid/ready byte port.
module cycle_count_reporter #(
    parameter int TIMER_SIZE = 32,
    parameter int TERMINATE  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  capture,
    input  logic [TIMER_SIZE-1:0] clock_cycles,
    output logic                  busy,
    output logic                  dropped,
    output logic [7:0]            byte_data,
    output logic                  byte_valid,
    input  logic                  byte_ready
);

    localparam int NDIG  = TIMER_SIZE / 4;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, DIGIT, CR, LF} state_t;

    state_t                state_q;
    logic [TIMER_SIZE-1:0] value_q;
    logic [IDX_W-1:0]      idx_q;
    logic [7:0]            byte_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  dropped_q;
    logic                  xfer;

    assign xfer = valid_q & byte_ready;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Digit 0 is the most-significant nibble.
    function automatic logic [7:0] digit_at(input logic [TIMER_SIZE-1:0] v,
                                            input logic [IDX_W-1:0]      idx);
        int shift;
        shift = 4 * (NDIG - 1 - int'(idx));
        return hex_char(4'(v >> shift));
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            value_q   <= '0;
            idx_q     <= '0;
            byte_q    <= 8'h00;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            // busy_q is still high on the final-transfer cycle, so a capture there is dropped too.
            dropped_q <= capture & busy_q;
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        value_q <= clock_cycles;
                        idx_q   <= '0;
                        byte_q  <= digit_at(clock_cycles, {IDX_W{1'b0}});
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= DIGIT;
                    end
                end
                DIGIT: begin
                    if (xfer) begin
                        if (idx_q == LAST_IDX) begin
                            if (TERMINATE != 0) begin
                                byte_q  <= 8'h0D;
                                state_q <= CR;
                            end else begin
                                byte_q  <= 8'h00;
                                valid_q <= 1'b0;
                                busy_q  <= 1'b0;
                                state_q <= IDLE;
                            end
                        end else begin
                            idx_q  <= idx_q + 1'b1;
                            byte_q <= digit_at(value_q, idx_q + 1'b1);
                        end
                    end
                end
                CR: begin
                    if (xfer) begin
                        byte_q  <= 8'h0A;
                        state_q <= LF;
                    end
                end
                LF: begin
                    if (xfer) begin
                        byte_q  <= 8'h00;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign dropped    = dropped_q;
    assign byte_data  = byte_q;
    assign byte_valid = valid_q;

endmodule
